// File: rtl/float_accumulator_pkg.sv
// Shared single-precision float constants, field layout and helpers used by
// the vector accumulator and its adder.
package float_accumulator_pkg;

    localparam int FP_W       = 32;
    localparam int FP_EXP_W   = 8;
    localparam int FP_FRAC_W  = 23;

    localparam logic [FP_W-1:0]     FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX  = 8'hFF;
    localparam logic [FP_W-1:0]     FP_QNAN     = 32'h7FC0_0000;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    // Inf or NaN: the exponent field is all ones.
    function automatic logic fp_is_special(input logic [FP_W-1:0] x);
        return x[FP_W-2:FP_FRAC_W] == FP_EXP_MAX;
    endfunction

endpackage

// File: rtl/float_accumulator_fadd.sv
// FAdd: combinational IEEE-754 single-precision adder, round-to-nearest-even,
// full subnormal support, canonical quiet NaN on invalid or NaN operands.
module float_accumulator_fadd
    import float_accumulator_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] y
);

    fp32_t       fa, fb, fbig, fsmall;
    logic        swap, eff_sub;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [8:0]  e_big, e_small, d, e_n, sh, sh_lim;
    logic [23:0] m_big, m_small;
    logic [27:0] big_ext, small_ext0, small_ext, lost_mask, r;
    logic [26:0] n;
    logic [4:0]  lz;
    logic        rup;
    logic [7:0]  exp_field;
    logic [30:0] mag;

    always_comb begin
        fa     = a;
        fb     = b;
        a_nan  = (fa.exp == FP_EXP_MAX) && (fa.frac != '0);
        b_nan  = (fb.exp == FP_EXP_MAX) && (fb.frac != '0);
        a_inf  = (fa.exp == FP_EXP_MAX) && (fa.frac == '0);
        b_inf  = (fb.exp == FP_EXP_MAX) && (fb.frac == '0);

        // Order by magnitude so the datapath only ever subtracts small from big.
        swap    = b[30:0] > a[30:0];
        fbig    = swap ? fb : fa;
        fsmall  = swap ? fa : fb;
        eff_sub = fbig.sign ^ fsmall.sign;

        e_big   = (fbig.exp == '0)   ? 9'd1 : {1'b0, fbig.exp};
        e_small = (fsmall.exp == '0) ? 9'd1 : {1'b0, fsmall.exp};
        m_big   = {fbig.exp != '0, fbig.frac};
        m_small = {fsmall.exp != '0, fsmall.frac};
        d       = e_big - e_small;

        // Layout: [27] carry, [26] hidden bit, [25:3] fraction, [2:0] guard/round/sticky.
        big_ext    = {1'b0, m_big, 3'b000};
        small_ext0 = {1'b0, m_small, 3'b000};
        lost_mask  = '0;
        small_ext  = '0;
        if (d >= 9'd27) begin
            small_ext = {27'b0, |m_small};
        end else begin
            lost_mask = (28'd1 << d[4:0]) - 28'd1;
            small_ext = (small_ext0 >> d[4:0]) | {27'b0, |(small_ext0 & lost_mask)};
        end

        r = eff_sub ? (big_ext - small_ext) : (big_ext + small_ext);

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (r[i]) lz = 5'(26 - i);
        end

        // Left shift stops at the minimum exponent, leaving a subnormal result.
        sh_lim = e_big - 9'd1;
        if (r[27]) begin
            n   = r[27:1] | {26'b0, r[0]};
            e_n = e_big + 9'd1;
            sh  = '0;
        end else begin
            sh  = ({4'b0, lz} < sh_lim) ? {4'b0, lz} : sh_lim;
            n   = r[26:0] << sh;
            e_n = e_big - sh;
        end

        exp_field = n[26] ? e_n[7:0] : 8'd0;
        rup       = n[2] & (n[1] | n[0] | n[3]);
        // Rounding carry ripples into the exponent, covering renormalisation and overflow.
        mag       = {exp_field, n[25:3]} + {30'b0, rup};
        y         = {fbig.sign, mag};

        if (r == '0) begin
            y = {~eff_sub & fbig.sign, 31'b0};
        end else if (n[26] && (e_n >= 9'd255)) begin
            y = {fbig.sign, FP_EXP_MAX, 23'b0};
        end

        if (a_nan || b_nan || (a_inf && b_inf && (fa.sign ^ fb.sign))) begin
            y = FP_QNAN;
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end
    end

endmodule

// File: rtl/float_accumulator.sv
// Streaming float vector accumulator: sums beats up to in_last, then holds
// sum/count/special until the consumer takes them.
module float_accumulator
    import float_accumulator_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [FP_W-1:0]  sum,
    output logic [CNT_W-1:0] count,
    output logic             special,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [FP_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             spec_reg, spec_next;
    logic [FP_W-1:0]  sum_reg, sum_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             special_reg, special_next;

    logic             in_fire, first_beat;
    logic [FP_W-1:0]  fadd_y, beat_acc;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat_spec;

    float_accumulator_fadd u_fadd (
        .a (acc_reg),
        .b (in_data),
        .y (fadd_y)
    );

    assign in_ready  = (state_reg == ST_ACC);
    assign out_valid = (state_reg == ST_HOLD);
    assign sum       = sum_reg;
    assign count     = count_reg;
    assign special   = special_reg;

    // The element counter doubles as the first-beat marker: it only reads 0
    // before the first beat, because it saturates instead of wrapping.
    assign in_fire    = in_ready && in_valid;
    assign first_beat = (cnt_reg == '0);
    assign beat_acc   = first_beat ? in_data : fadd_y;
    assign beat_cnt   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    assign beat_spec  = spec_reg | fp_is_special(in_data) | fp_is_special(beat_acc);

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        spec_next    = spec_reg;
        sum_next     = sum_reg;
        count_next   = count_reg;
        special_next = special_reg;
        case (state_reg)
            ST_ACC: begin
                if (in_fire) begin
                    if (in_last) begin
                        sum_next     = beat_acc;
                        count_next   = beat_cnt;
                        special_next = beat_spec;
                        acc_next     = FP_POS_ZERO;
                        cnt_next     = '0;
                        spec_next    = 1'b0;
                        state_next   = ST_HOLD;
                    end else begin
                        acc_next  = beat_acc;
                        cnt_next  = beat_cnt;
                        spec_next = beat_spec;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_ACC;
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_ACC;
            acc_reg     <= FP_POS_ZERO;
            cnt_reg     <= '0;
            spec_reg    <= 1'b0;
            sum_reg     <= FP_POS_ZERO;
            count_reg   <= '0;
            special_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            spec_reg    <= spec_next;
            sum_reg     <= sum_next;
            count_reg   <= count_next;
            special_reg <= special_next;
        end
    end

endmodule

// File: tb/tb_float_accumulator.sv
// Self-checking bench for float_accumulator: table of vectors through a result
// scoreboard, plus hand sequences for stall, reset and counter saturation.
module tb_float_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] sum;
    logic [15:0] count;
    logic        special;
    logic        out_valid;
    logic        out_ready = 1'b1;

    logic [31:0] in2_data = '0;
    logic        in2_valid = 1'b0;
    logic        in2_last = 1'b0;
    logic        in2_ready;
    logic [31:0] sum2;
    logic [1:0]  count2;
    logic        special2;
    logic        out2_valid;
    logic        out2_ready = 1'b1;

    always #5 clk = ~clk;

    float_accumulator #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .sum(sum), .count(count), .special(special),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    float_accumulator #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in2_data), .in_valid(in2_valid), .in_last(in2_last),
        .in_ready(in2_ready), .sum(sum2), .count(count2), .special(special2),
        .out_valid(out2_valid), .out_ready(out2_ready)
    );

    typedef struct {
        int               n;
        logic [3:0][31:0] beats;
        logic [31:0]      sum;
        int               cnt;
        logic             spec;
    } vec_t;

    typedef struct packed {
        logic [31:0] sum;
        logic [15:0] cnt;
        logic        spec;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] s, input int c,
                                input logic sp);
        vec_t v;
        v.n = n;
        v.beats = '0;
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.sum = s;
        v.cnt = c;
        v.spec = sp;
        return v;
    endfunction

    task automatic send_vec(input vec_t v);
        int   guard;
        res_t e;
        e.sum  = v.sum;
        e.cnt  = v.cnt[15:0];
        e.spec = v.spec;
        for (int i = 0; i < v.n; i++) begin
            guard = 0;
            while (!in_ready && guard < 20) begin
                step();
                guard++;
            end
            if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = v.beats[i];
            in_last  = (i == v.n - 1);
            if (i == v.n - 1) exp_q.push_back(e);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("out_valid_latency", {31'b0, out_valid}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            $display("result sum=%h count=%0d special=%0b", sum, count, special);
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", sum, mon_e.sum);
                check("count", {16'b0, count}, {16'b0, mon_e.cnt});
                check("special", {31'b0, special}, {31'b0, mon_e.spec});
            end
        end
    end

    initial begin
        int guard;

        tbl[0]  = mk(2, 32'h3FC00000, 32'h40200000, 32'h0, 32'h40800000, 2, 1'b0);
        tbl[1]  = mk(2, 32'hBF800000, 32'h3F800000, 32'h0, 32'h00000000, 2, 1'b0);
        tbl[2]  = mk(1, 32'h80000000, 32'h0, 32'h0,        32'h80000000, 1, 1'b0);
        tbl[3]  = mk(2, 32'h7F800000, 32'h40A00000, 32'h0, 32'h7F800000, 2, 1'b1);
        tbl[4]  = mk(1, 32'h3F800000, 32'h0, 32'h0,        32'h3F800000, 1, 1'b0);
        tbl[5]  = mk(3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40C00000, 3, 1'b0);
        tbl[6]  = mk(2, 32'h3F800000, 32'h33800000, 32'h0, 32'h3F800000, 2, 1'b0);
        tbl[7]  = mk(2, 32'h3F800000, 32'h33C00000, 32'h0, 32'h3F800001, 2, 1'b0);
        tbl[8]  = mk(2, 32'h00000001, 32'h00000001, 32'h0, 32'h00000002, 2, 1'b0);
        tbl[9]  = mk(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h7F800000, 2, 1'b1);
        tbl[10] = mk(2, 32'hBFC00000, 32'h3E800000, 32'h0, 32'hBFA00000, 2, 1'b0);
        tbl[11] = mk(2, 32'h80000000, 32'h80000000, 32'h0, 32'h80000000, 2, 1'b0);
        tbl[12] = mk(2, 32'h7FC00000, 32'h3F800000, 32'h0, 32'h7FC00000, 2, 1'b1);

        step();
        step();
        rst = 1'b0;
        check("reset_sum", sum, 32'h0);
        check("reset_count", {16'b0, count}, 32'd0);
        check("reset_special", {31'b0, special}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        foreach (tbl[i]) send_vec(tbl[i]);

        // in_last without in_valid must not end a vector
        step();
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        check("stray_last_no_result", {31'b0, out_valid}, 32'd0);
        send_vec(mk(2, 32'h3FC00000, 32'h40200000, 32'h0, 32'h40800000, 2, 1'b0));

        // Consumer stalls for 3 cycles in HOLD
        step();
        out_ready = 1'b0;
        send_vec(mk(1, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check("stall_sum", sum, 32'h40000000);
            step();
        end
        out_ready = 1'b1;
        step();
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        send_vec(mk(1, 32'h40400000, 32'h0, 32'h0, 32'h40400000, 1, 1'b0));
        step();

        // Reset in the middle of a vector, with a last beat offered alongside
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        step();
        step();
        in_last = 1'b1;
        rst     = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("midrst_sum", sum, 32'h0);
        check("midrst_count", {16'b0, count}, 32'd0);
        check("midrst_special", {31'b0, special}, 32'd0);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        send_vec(mk(1, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 1, 1'b0));
        step();

        // Narrow counter saturates while the sum keeps accumulating
        for (int i = 0; i < 5; i++) begin
            in2_valid = 1'b1;
            in2_data  = 32'h3F800000;
            in2_last  = (i == 4);
            step();
        end
        in2_valid = 1'b0;
        in2_last  = 1'b0;
        check("sat_out_valid", {31'b0, out2_valid}, 32'd1);
        check("sat_sum", sum2, 32'h40A00000);
        check("sat_count", {30'b0, count2}, 32'd3);
        check("sat_special", {31'b0, special2}, 32'd0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
